// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM encoding, SPI mode
// constants and width helpers used by the sequencer and its tick divider.
package spi_pkg;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 2'd0;
  localparam spi_state_t ST_SETUP = 2'd1;
  localparam spi_state_t ST_XFER  = 2'd2;
  localparam spi_state_t ST_HOLD  = 2'd3;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Edge counter must hold 2*dw, the number of SCLK edges in one word.
  function automatic int edge_cnt_w(input int dw);
    return $clog2(2 * dw) + 1;
  endfunction

  // Divider must count to 2^(2^rg-1)-1, the largest ratio exponent.
  function automatic int tick_cnt_w(input int rg);
    return (1 << rg) - 1;
  endfunction

endpackage

// File: rtl/spi_ratio_tick.sv
// Tick-enable generator: one tick every 2^ratio_i clk_i cycles, held at zero
// while clr_i is high so every transfer starts on a fresh period.
module spi_ratio_tick
  import spi_pkg::*;
#(
  parameter int RATIO_GRADE = 3
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   clr_i,
  input  logic [RATIO_GRADE-1:0] ratio_i,
  output logic                   tick_o
);

  localparam int CW = tick_cnt_w(RATIO_GRADE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] lim;

  // 2^ratio-1 as a low-bit mask; the largest exponent yields all ones.
  assign lim    = ~({CW{1'b1}} << ratio_i);
  assign tick_o = !clr_i && (cnt_q == lim);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)            cnt_q <= '0;
    else if (clr_i || tick_o) cnt_q <= '0;
    else                      cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// SPI master word sequencer: CS setup, 2*DATA_WIDTH SCLK edges, CS hold, done.
// Optional SPI_LSB_FIRST_EN adds lsb_first_i to select shift direction.
module spi_xfer_seq
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RATIO_GRADE = 3
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   start_i,
  input  logic [RATIO_GRADE-1:0] ratio_i,
  input  logic                   cpol_i,
  input  logic                   cpha_i,
  input  logic [DATA_WIDTH-1:0]  tx_data_i,
  input  logic                   miso_i,
`ifdef SPI_LSB_FIRST_EN
  input  logic                   lsb_first_i,
`endif
  output logic [DATA_WIDTH-1:0]  rx_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   sclk_o,
  output logic                   mosi_o,
  output logic                   cs_n_o
);

  localparam int             EW        = edge_cnt_w(DATA_WIDTH);
  localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DATA_WIDTH);

  spi_state_t             state_q;
  logic [RATIO_GRADE-1:0] ratio_q;
  logic                   cpol_q, cpha_q, lsb_q;
  logic [DATA_WIDTH-1:0]  tx_sh_q, rx_sh_q, rx_shifted, tx_shifted;
  logic [EW-1:0]          edge_q, edge_nxt;
  logic                   sclk_q, done_q;
  logic                   tick, xfer_tick, leading, sample_en, shift_en;
  logic                   start_ok;

  spi_ratio_tick #(.RATIO_GRADE(RATIO_GRADE)) u_tick (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clr_i    (state_q == ST_IDLE),
    .ratio_i  (ratio_q),
    .tick_o   (tick)
  );

  assign start_ok  = (state_q == ST_IDLE) && start_i;
  assign xfer_tick = (state_q == ST_XFER) && tick;
  assign edge_nxt  = edge_q + EW'(1);
  assign leading   = edge_nxt[0];

  // cpha=0 samples on leading and shifts on trailing; cpha=1 swaps them.
  // The first leading (cpha=1) / last trailing (cpha=0) edge never shifts.
  assign sample_en = xfer_tick && (leading ^ cpha_q);
  assign shift_en  = xfer_tick && !(leading ^ cpha_q)
                     && (edge_nxt != LAST_EDGE) && (edge_nxt != EW'(1));

`ifdef SPI_LSB_FIRST_EN
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)     lsb_q <= 1'b0;
    else if (start_ok) lsb_q <= lsb_first_i;
  end
`else
  assign lsb_q = 1'b0;
`endif

  always_comb begin
    rx_shifted = {rx_sh_q[DATA_WIDTH-2:0], miso_i};
    tx_shifted = tx_sh_q << 1;
    if (lsb_q) begin
      rx_shifted = {miso_i, rx_sh_q[DATA_WIDTH-1:1]};
      tx_shifted = tx_sh_q >> 1;
    end
  end

  // Transfer configuration is frozen at start.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ratio_q <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else if (start_ok) begin
      ratio_q <= ratio_i;
      cpol_q  <= cpol_i;
      cpha_q  <= cpha_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      edge_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE:  if (start_ok) state_q <= ST_SETUP;
        ST_SETUP: if (tick) begin
          edge_q  <= '0;
          state_q <= ST_XFER;
        end
        ST_XFER:  if (tick) begin
          edge_q <= edge_nxt;
          if (edge_nxt == LAST_EDGE) state_q <= ST_HOLD;
        end
        ST_HOLD:  if (tick) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // SCLK starts at the new idle level and toggles once per XFER tick.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)      sclk_q <= 1'b0;
    else if (start_ok)  sclk_q <= cpol_i;
    else if (xfer_tick) sclk_q <= ~sclk_q;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tx_sh_q <= '0;
      rx_sh_q <= '0;
    end else if (start_ok) begin
      tx_sh_q <= tx_data_i;
      rx_sh_q <= '0;
    end else begin
      if (shift_en)  tx_sh_q <= tx_shifted;
      if (sample_en) rx_sh_q <= rx_shifted;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                                rx_data_o <= '0;
    else if ((state_q == ST_HOLD) && tick)        rx_data_o <= rx_sh_q;
  end

  assign busy_o = (state_q != ST_IDLE);
  assign cs_n_o = (state_q == ST_IDLE);
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign mosi_o = busy_o && (lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1]);

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq: modes 0/3, ratio freeze, start filtering,
// back-to-back start, async reset abort and (with SPI_LSB_FIRST_EN) LSB-first.
module tb_spi_xfer_seq;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       start;
  logic [2:0] ratio;
  logic       cpol, cpha;
  logic [7:0] tx;
  logic       miso;
`ifdef SPI_LSB_FIRST_EN
  logic       lsb_first;
`endif
  logic [7:0] rx_data;
  logic       busy, done, sclk, mosi, cs_n;

  spi_xfer_seq #(.DATA_WIDTH(8), .RATIO_GRADE(3)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .start_i     (start),
    .ratio_i     (ratio),
    .cpol_i      (cpol),
    .cpha_i      (cpha),
    .tx_data_i   (tx),
    .miso_i      (miso),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first_i (lsb_first),
`endif
    .rx_data_o   (rx_data),
    .busy_o      (busy),
    .done_o      (done),
    .sclk_o      (sclk),
    .mosi_o      (mosi),
    .cs_n_o      (cs_n)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  int         cyc = 0;
  int         busy_cnt, done_cnt, cs_falls, rises, last_rise, period_err;
  int         exp_period, lead, cs_hi_run, last_gap;
  logic [7:0] mosi_seq, slave_word;
  logic       loop, prev_cs, prev_sclk;
  bit         to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    busy_cnt = 0; done_cnt = 0; cs_falls = 0; rises = 0;
    last_rise = -1; period_err = 0; mosi_seq = 8'h00; lead = 0;
  endtask

  // One clock: sample outputs on the falling edge, update monitors and slave.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (!cs_n && prev_cs) begin cs_falls++; lead = 0; end
    if (cs_n) cs_hi_run++;
    else begin
      if (cs_hi_run > 0) last_gap = cs_hi_run;
      cs_hi_run = 0;
    end
    if (!cs_n && !prev_cs && (sclk != prev_sclk)) begin
      if (sclk != cpol) lead++;
      if (sclk) begin
        rises++;
        if (last_rise >= 0 && (cyc - last_rise) != exp_period) period_err++;
        last_rise = cyc;
      end
      if ((sclk != cpol) ^ cpha) mosi_seq = {mosi_seq[6:0], mosi};
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
    miso = loop ? mosi : slave_word[(lead == 0) ? 7 : 8 - lead];
  endtask

  task automatic run_until_done(input int max, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; ratio = 3'd0; cpol = 1'b0; cpha = 1'b0;
    tx = 8'h00; miso = 1'b0; loop = 1'b1; slave_word = 8'h00;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    prev_cs = 1'b1; prev_sclk = 1'b0; cs_hi_run = 0; last_gap = 0;
    exp_period = 2;
    clr_mon();
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rx",   rx_data, 8'h00);
    arst_n = 1'b1;
    tick(); tick();

    // Mode 0, ratio 0, loopback A5
    tx = 8'hA5; cpol = 0; cpha = 0; ratio = 3'd0; loop = 1; exp_period = 2;
    clr_mon();
    kick();
    run_until_done(100, to);
    chk("m0_timeout", to, 1'b0);
    chk("m0_rx",      rx_data, 8'hA5);
    chk("m0_busy",    busy_cnt, 18);
    chk("m0_rises",   rises, 8);
    chk("m0_period",  period_err, 0);
    chk("m0_mosi",    mosi_seq, 8'hA5);
    chk("m0_busy_dn", busy, 1'b0);
    tick();
    chk("m0_done_1c", done, 1'b0);
    chk("m0_sclk_idle", sclk, 1'b0);
    chk("m0_cs_idle", cs_n, 1'b1);

    // Mode 3, ratio 3, slave returns C3
    tx = 8'h3C; cpol = 1; cpha = 1; ratio = 3'd3; loop = 0; slave_word = 8'hC3;
    exp_period = 16;
    clr_mon();
    kick();
    run_until_done(400, to);
    chk("m3_timeout", to, 1'b0);
    chk("m3_rx",      rx_data, 8'hC3);
    chk("m3_busy",    busy_cnt, 144);
    chk("m3_rises",   rises, 8);
    chk("m3_period",  period_err, 0);
    chk("m3_mosi",    mosi_seq, 8'h3C);
    tick();
    chk("m3_sclk_idle", sclk, 1'b1);

    // Start during a transfer is ignored; start on done cycle is accepted
    tx = 8'h5A; cpol = 0; cpha = 0; ratio = 3'd0; loop = 1; exp_period = 2;
    tick();
    clr_mon();
    kick();
    repeat (4) tick();
    kick();
    run_until_done(100, to);
    chk("ign_timeout", to, 1'b0);
    chk("ign_done",    done_cnt, 1);
    chk("ign_csfall",  cs_falls, 1);
    chk("ign_rx",      rx_data, 8'h5A);
    tx = 8'h96;
    kick();
    chk("b2b_busy",  busy, 1'b1);
    chk("b2b_cs",    cs_n, 1'b0);
    run_until_done(100, to);
    chk("b2b_timeout", to, 1'b0);
    chk("b2b_gap",     last_gap, 1);
    chk("b2b_rx",      rx_data, 8'h96);
    chk("b2b_done",    done_cnt, 2);

    // Ratio change mid-transfer has no effect
    tx = 8'hC9; ratio = 3'd1; exp_period = 4;
    tick();
    clr_mon();
    kick();
    repeat (6) tick();
    ratio = 3'd4;
    run_until_done(300, to);
    chk("rat_timeout", to, 1'b0);
    chk("rat_period",  period_err, 0);
    chk("rat_busy",    busy_cnt, 36);
    chk("rat_rx",      rx_data, 8'hC9);

    // Async reset at SCLK edge 7 aborts without done
    tx = 8'hFF; ratio = 3'd0; exp_period = 2;
    tick();
    clr_mon();
    kick();
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rises >= 4) begin to = 1'b0; break; end
    end
    chk("ar_timeout", to, 1'b0);
    arst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    chk("ar_cs_n", cs_n, 1'b1);
    chk("ar_sclk", sclk, 1'b0);
    chk("ar_mosi", mosi, 1'b0);
    chk("ar_rx",   rx_data, 8'h00);
    tick(); tick();
    arst_n = 1'b1;
    repeat (30) tick();
    chk("ar_nodone", done_cnt, 0);
    chk("ar_idle",   busy, 1'b0);

`ifdef SPI_LSB_FIRST_EN
    // LSB first, mode 1, loopback 01
    tx = 8'h01; cpol = 0; cpha = 1; ratio = 3'd0; lsb_first = 1; exp_period = 2;
    tick();
    clr_mon();
    kick();
    run_until_done(100, to);
    chk("lsb_timeout", to, 1'b0);
    chk("lsb_mosi",    mosi_seq, 8'h80);
    chk("lsb_rx",      rx_data, 8'h01);
    lsb_first = 0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_seq.md
Name: spi_xfer_seq

Overview:
- SPI master transfer sequencer that owns the serial-clock ratio divider and runs one full-duplex word transfer per start request.
- Sequence per transfer: chip-select setup, SCLK edge generation, MOSI shift-out / MISO sample-in, chip-select hold, completion handshake.
- Sits between the register-mapped control/status bank (start, ratio, mode, data) and the SPI pins.
- Replaces free-running divided clocks with a single-clock tick-enable scheme on clk_i.

Parameters:
- DATA_WIDTH, 8, bits per transfer.
- RATIO_GRADE, 3, width of ratio_i. Tick period is 2^ratio_i clk_i cycles.

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  transfer request pulse/level; sampled only in IDLE.
- ratio_i  in  RATIO_GRADE  clock ratio exponent; latched at start.
- cpol_i  in  1  SCLK idle level; latched at start.
- cpha_i  in  1  sample phase; latched at start.
- tx_data_i  in  DATA_WIDTH  word to transmit; latched at start.
- miso_i  in  1  serial input.
- rx_data_o  out  DATA_WIDTH  last received word.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- sclk_o  out  1  serial clock.
- mosi_o  out  1  serial output.
- cs_n_o  out  1  chip select, active low.

Behaviour:
- Reset (asynchronous, arst_n_i=0): FSM=IDLE; busy_o=0, done_o=0, cs_n_o=1, sclk_o=0, mosi_o=0, rx_data_o=0; divider cleared. Reset mid-transfer aborts immediately with no done_o pulse.
- Divider (tick generator):
  - Counter is RATIO_GRADE-bit-exponent wide and is cleared in IDLE.
  - tick=1 when count == 2^ratio_q-1; count wraps to 0 on tick.
  - ratio_q=0 gives a tick every cycle.
- FSM states: IDLE, SETUP, XFER, HOLD. All non-IDLE transitions occur on tick only.
- IDLE:
  - cs_n_o=1, sclk_o=cpol_q.
  - On start_i=1: latch ratio/cpol/cpha/tx into the shift register; go to SETUP; busy_o=1 from the next cycle.
- SETUP:
  - cs_n_o=0; mosi_o=first data bit.
  - After 1 tick, go to XFER with edge counter=0.
- XFER:
  - Each tick toggles sclk_o and increments the edge counter (width clog2(2*DATA_WIDTH)+1).
  - Odd-numbered edges (1st, 3rd, ...) are leading; even-numbered edges are trailing.
  - cpha=0: sample miso_i on the leading edge; shift mosi on the trailing edge (except the last trailing edge).
  - cpha=1: shift mosi on the leading edge (first leading edge presents MSB); sample on the trailing edge.
  - After 2*DATA_WIDTH ticks, sclk_o is back at cpol_q; go to HOLD.
- HOLD:
  - cs_n_o=0, sclk_o=cpol_q.
  - After 1 tick: go to IDLE, load rx_data_o, busy_o=0, done_o=1 for one cycle.
- Bit order: MSB first.
- Total busy duration: (2*DATA_WIDTH+2)*2^ratio_q cycles.
- start_i while busy_o=1 is ignored, not queued.
- start_i in the same cycle done_o=1 (FSM in IDLE) is accepted.
- Changes to ratio_i, cpol_i or cpha_i mid-transfer have no effect.
- rx_data_o holds its value until the next completed transfer.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: adds input port lsb_first_i (1 bit), latched at start. When 1, both MOSI and MISO shift LSB first. Shift direction is selected by the latched bit.
- Undefined: port absent; always MSB first.

Decomposition:
- Package spi_pkg:
  - FSM state typedef/localparams (IDLE=2'd0, SETUP=2'd1, XFER=2'd2, HOLD=2'd3).
  - Edge-count width function.
  - SPI mode constants (MODE0..MODE3 as {cpol,cpha}).
- One sub-module, spi_ratio_tick:
  - Inputs: clk_i, arst_n_i, clr_i, ratio_i.
  - Output: tick_o.
  - Separately unit-testable.

Test Plan:
- Mode 0, ratio=0, tx=0xA5, miso looped to mosi -> rx_data_o=0xA5; busy_o high exactly 18 cycles; 8 sclk pulses with period 2 cycles; sclk_o idles 0.
- Mode 3 (cpol=1, cpha=1), ratio=3, tx=0x3C, miso driven by slave model with 0xC3 -> rx_data_o=0xC3; busy_o high 144 cycles; sclk_o idles 1; SCLK period 16 cycles.
- start_i pulsed at cycle 5 of an active transfer -> ignored; exactly one done_o; no second cs_n_o assertion. Back-to-back start on the done_o cycle -> second transfer begins, cs_n_o deasserted for exactly 1 cycle.
- ratio_i changed from 1 to 4 mid-transfer -> SCLK period stays 4 cycles until done_o.
- arst_n_i pulsed low at edge 7 of a transfer -> all outputs at reset values the same cycle; no done_o; rx_data_o=0.
- With SPI_LSB_FIRST_EN, lsb_first_i=1, tx=0x01, mode 1 -> mosi_o first bit=1, subsequent bits 0; loopback rx_data_o=0x01.
